// File: rtl/max7219_chain_display_if.sv
// Frame request/status and SPI pins of max7219_chain_display; master drives pixels/intensity/update.
interface max7219_chain_display_if #(
  parameter int NUM_DEV = 4
);
  logic [64*NUM_DEV-1:0] pixels;
  logic [3:0]            intensity;
  logic                  update;
  logic                  busy;
  logic                  frame_done;
  logic                  sck;
  logic                  mosi;
  logic                  cs;

  modport master (
    output pixels, intensity, update,
    input  busy, frame_done, sck, mosi, cs
  );

  modport slave (
    input  pixels, intensity, update,
    output busy, frame_done, sck, mosi, cs
  );
endinterface

// File: rtl/max7219_chain_display.sv
// Drives a daisy chain of MAX7219s: 13-write init after reset, then 9-write frames on update.
// Optional MAX7219_AUTO_REFRESH_EN re-sends the last frame 2*CLK_DIV cycles after each completion.
module max7219_chain_display #(
  parameter int         NUM_DEV    = 4,
  parameter int         CLK_DIV    = 4,
  parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
  input  logic                   clk,
  input  logic                   rst,
  max7219_chain_display_if.slave bus
);

  localparam int         NBITS      = 16 * NUM_DEV;
  localparam int         PER        = 2 * CLK_DIV;
  localparam int         BIT_W      = $clog2(NBITS + 1);
  localparam int         DIV_W      = $clog2(PER + 1);
  localparam logic [3:0] INIT_LAST  = 4'd12;
  localparam logic [3:0] FRAME_LAST = 4'd8;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME} state_e;
  typedef enum logic [1:0] {SH_LOAD, SH_SHIFT, SH_GAP} shift_e;

  state_e                state_q, state_d;
  shift_e                sh_q, sh_d;
  logic [3:0]            step_q, step_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [NBITS-1:0]      sr_q, sr_d;
  logic [64*NUM_DEV-1:0] pix_q, pix_d;
  logic [3:0]            inten_q, inten_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;

`ifdef MAX7219_AUTO_REFRESH_EN
  logic                  auto_arm_q, auto_arm_d;
  logic [DIV_W-1:0]      auto_cnt_q, auto_cnt_d;
`endif

  logic [NBITS-1:0]      tx_word;
  logic [7:0]            addr_w;
  logic [7:0]            init_dat;
  logic [2:0]            dig;
  logic                  tx_done;
  logic                  last_step;
  logic                  start_frame;
  logic                  auto_fire;

  // Every device in one transaction gets the same register; device d occupies sr[16d +: 16].
  always_comb begin
    addr_w   = 8'h00;
    init_dat = 8'h00;
    dig      = 3'd0;
    tx_word  = '0;
    if (state_q == ST_INIT) begin
      case (step_q)
        4'd0:    begin addr_w = 8'h0B; init_dat = {5'd0, SCAN_LIMIT}; end
        4'd1:    addr_w = 8'h09;
        4'd2:    begin addr_w = 8'h0C; init_dat = 8'h01; end
        4'd3:    addr_w = 8'h0F;
        4'd4:    begin addr_w = 8'h0A; init_dat = {4'd0, bus.intensity}; end
        default: addr_w = {4'd0, step_q - 4'd4};
      endcase
      for (int d = 0; d < NUM_DEV; d++) tx_word[16*d +: 16] = {addr_w, init_dat};
    end else begin
      addr_w = {4'd0, step_q};
      dig    = step_q[2:0] - 3'd1;
      for (int d = 0; d < NUM_DEV; d++) begin
        if (step_q == 4'd0) tx_word[16*d +: 16] = {8'h0A, 4'd0, inten_q};
        else                tx_word[16*d +: 16] = {addr_w, pix_q[64*d + 8*(7 - int'(dig)) +: 8]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    step_d      = step_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    pix_d       = pix_q;
    inten_d     = inten_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    tx_done     = 1'b0;
    start_frame = 1'b0;
    auto_fire   = 1'b0;
`ifdef MAX7219_AUTO_REFRESH_EN
    auto_arm_d  = auto_arm_q;
    auto_cnt_d  = auto_cnt_q;
    if (state_q == ST_IDLE && auto_arm_q) begin
      if (auto_cnt_q == DIV_W'(PER - 1)) auto_fire = 1'b1;
      else                               auto_cnt_d = auto_cnt_q + 1'b1;
    end
`endif

    if (state_q != ST_IDLE) begin
      case (sh_q)
        SH_LOAD: begin
          sh_d  = SH_SHIFT;
          div_d = '0;
          bit_d = '0;
          sr_d  = tx_word;
        end
        SH_SHIFT: begin
          if (div_q == DIV_W'(PER - 1)) begin
            div_d = '0;
            if (bit_q == BIT_W'(NBITS - 1)) begin
              sh_d  = SH_GAP;
              bit_d = '0;
            end else begin
              bit_d = bit_q + 1'b1;
              sr_d  = {sr_q[NBITS-2:0], 1'b0};
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        SH_GAP: begin
          if (div_q == DIV_W'(PER - 1)) begin
            div_d   = '0;
            sh_d    = SH_LOAD;
            tx_done = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        default: sh_d = SH_LOAD;
      endcase
    end

    last_step = (state_q == ST_INIT  && step_q == INIT_LAST) ||
                (state_q == ST_FRAME && step_q == FRAME_LAST);
    if (tx_done) step_d = last_step ? 4'd0 : step_q + 4'd1;

    case (state_q)
      ST_INIT, ST_FRAME: begin
        if (tx_done && last_step) begin
          done_d = (state_q == ST_FRAME);
          if (pending_q || bus.update) start_frame = 1'b1;
          else                         state_d     = ST_IDLE;
        end else if (bus.update) begin
          pending_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.update || auto_fire) start_frame = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase

`ifdef MAX7219_AUTO_REFRESH_EN
    // Arming after init as well lets refresh run without any update ever arriving.
    if (tx_done && last_step) begin
      auto_arm_d = 1'b1;
      auto_cnt_d = '0;
    end
    if (start_frame) auto_arm_d = 1'b0;
`endif

    if (start_frame) begin
      state_d   = ST_FRAME;
      pending_d = 1'b0;
      pix_d     = bus.pixels;
      inten_d   = bus.intensity;
    end

    busy_d = (state_d != ST_IDLE) || pending_d;
    cs_d   = (sh_d != SH_SHIFT);
    sck_d  = (sh_d == SH_SHIFT) && (div_d >= DIV_W'(CLK_DIV));
    mosi_d = (sh_d == SH_SHIFT) && sr_d[NBITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sh_q       <= SH_LOAD;
      step_q     <= 4'd0;
      div_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      pix_q      <= '0;
      inten_q    <= 4'd0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
`ifdef MAX7219_AUTO_REFRESH_EN
      auto_arm_q <= 1'b0;
      auto_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      step_q     <= step_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      pix_q      <= pix_d;
      inten_q    <= inten_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
`ifdef MAX7219_AUTO_REFRESH_EN
      auto_arm_q <= auto_arm_d;
      auto_cnt_q <= auto_cnt_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.cs         = cs_q;
  assign bus.sck        = sck_q;
  assign bus.mosi       = mosi_q;

endmodule

// File: tb/tb_max7219_chain_display.sv
// Bench for max7219_chain_display: expected SPI transactions queued at stimulus time, decoded off the pins and compared.
module tb_max7219_chain_display;

  localparam int NUM_DEV = 2;
  localparam int CLK_DIV = 2;
  localparam int W       = 16 * NUM_DEV;
  localparam int PW      = 64 * NUM_DEV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max7219_chain_display_if #(.NUM_DEV(NUM_DEV)) bus_if ();

  max7219_chain_display #(
    .NUM_DEV   (NUM_DEV),
    .CLK_DIV   (CLK_DIV),
    .SCAN_LIMIT(3'd7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [W-1:0] sb[$];
  int fd_count = 0;
  int fd_exp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction as the chain sees it: device NUM_DEV-1's 16-bit word leaves first.
  function automatic logic [W-1:0] mk_tx(input logic [7:0] addr, input logic [8*NUM_DEV-1:0] dat);
    logic [63:0] acc;
    acc = 64'd0;
    for (int d = NUM_DEV - 1; d >= 0; d--)
      acc = acc * 64'd65536 + 64'(addr) * 64'd256 + 64'(dat[8*d +: 8]);
    return acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] mk_all(input logic [7:0] addr, input logic [7:0] data);
    return mk_tx(addr, {NUM_DEV{data}});
  endfunction

  task automatic push_init(input logic [3:0] inten);
    sb.push_back(mk_all(8'h0B, 8'h07));
    sb.push_back(mk_all(8'h09, 8'h00));
    sb.push_back(mk_all(8'h0C, 8'h01));
    sb.push_back(mk_all(8'h0F, 8'h00));
    sb.push_back(mk_all(8'h0A, {4'h0, inten}));
    for (int k = 1; k <= 8; k++) sb.push_back(mk_all(8'(k), 8'h00));
  endtask

  task automatic push_frame(input logic [PW-1:0] pix, input logic [3:0] inten);
    logic [8*NUM_DEV-1:0] dat;
    sb.push_back(mk_all(8'h0A, {4'h0, inten}));
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < NUM_DEV; d++) dat[8*d +: 8] = pix[64*d + 63 - 8*k -: 8];
      sb.push_back(mk_tx(8'(k + 1), dat));
    end
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  // SPI monitor: decodes each cs-low window and checks it against the scoreboard.
  logic         p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
  logic [W-1:0] m_word;
  int           m_low, m_high, m_nbits;
  bit           m_viol, m_idle_viol, m_have_gap;

  initial begin
    logic [W-1:0] exp_w;
    m_word = '0; m_low = 0; m_high = 0; m_nbits = 0;
    m_viol = 0; m_idle_viol = 0; m_have_gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_have_gap = 0; m_idle_viol = 0; m_nbits = 0; m_low = 0; m_high = 0;
        p_cs = 1'b1; p_sck = 1'b0; p_mosi = 1'b0;
      end else begin
        if (bus_if.cs) begin
          if (bus_if.sck || bus_if.mosi) m_idle_viol = 1;
          if (!p_cs) begin
            check("cs_low_cycles", m_low, 32 * NUM_DEV * CLK_DIV);
            check("bit_count", m_nbits, W);
            check("mosi_change_timing", m_viol, 0);
            if (sb.size() == 0) check("unexpected_tx", 1, 0);
            else begin
              exp_w = sb.pop_front();
              check("tx_word", m_word, exp_w);
            end
            m_high = 0;
            m_have_gap = 1;
          end
          m_high++;
        end else begin
          if (p_cs) begin
            if (m_have_gap) check("cs_high_gap_min", m_high >= 2 * CLK_DIV, 1);
            check("idle_sck_mosi_low", m_idle_viol, 0);
            m_idle_viol = 0; m_low = 0; m_nbits = 0; m_word = '0; m_viol = 0;
          end else if (bus_if.mosi !== p_mosi && !(p_sck && !bus_if.sck)) begin
            m_viol = 1;
          end
          m_low++;
          if (bus_if.sck && !p_sck) begin
            m_word = {m_word[W-2:0], bus_if.mosi};
            m_nbits++;
          end
        end
        p_cs = bus_if.cs; p_sck = bus_if.sck; p_mosi = bus_if.mosi;
      end
    end
  end

  initial begin
    logic p_fd;
    p_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.frame_done) begin
        fd_count++;
        check("frame_done_one_cycle", p_fd, 0);
      end
      p_fd = bus_if.frame_done;
    end
  end

  task automatic pulse_update();
    @(posedge clk); #1 bus_if.update = 1'b1;
    @(posedge clk); #1 bus_if.update = 1'b0;
    @(negedge clk);
    check("busy_after_update", bus_if.busy, 1);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus_if.busy) begin ok = 1; break; end
    end
    check({name, "_idle_reached"}, ok, 1);
    repeat (4) @(negedge clk);
    check({name, "_scoreboard_drained"}, sb.size(), 0);
    check({name, "_frame_done_count"}, fd_count, fd_exp);
  endtask

  task automatic count_cs_rises(input string name, input int n, input int max_cyc);
    int   seen;
    logic pc;
    seen = 0;
    pc   = bus_if.cs;
    for (int i = 0; i < max_cyc && seen < n; i++) begin
      @(negedge clk);
      if (bus_if.cs && !pc) seen++;
      pc = bus_if.cs;
    end
    check({name, "_cs_rises"}, seen, n);
  endtask

  initial begin
    logic [PW-1:0] pix;
    logic [3:0]    inten;
    bit            ok;
    int            rises;
    logic          pk;

    rst = 1'b1;
    bus_if.update    = 1'b0;
    bus_if.pixels    = '0;
    bus_if.intensity = 4'h3;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_cs", bus_if.cs, 1);
    check("rst_sck", bus_if.sck, 0);
    check("rst_mosi", bus_if.mosi, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_frame_done", bus_if.frame_done, 0);

    push_init(4'h3);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("busy_after_rst_release", bus_if.busy, 1);
    wait_idle("init", 4000);

    // Digit-1 bytes placed per device, intensity random.
    pix = rand_pix();
    pix[127:120] = 8'hA5;
    pix[63:56]   = 8'h3C;
    inten = 4'($urandom_range(0, 15));
    bus_if.pixels = pix; bus_if.intensity = inten;
    push_frame(pix, inten);
    fd_exp++;
    pulse_update();
    wait_idle("frame_a", 3000);

    // Inputs change mid-frame and three extra requests collapse into one follow-up frame.
    pix = rand_pix();
    inten = 4'($urandom_range(0, 8));
    bus_if.pixels = pix; bus_if.intensity = inten;
    push_frame(pix, inten);
    pulse_update();
    repeat (300) @(negedge clk);
    pix = rand_pix();
    bus_if.pixels = pix; bus_if.intensity = 4'h9;
    push_frame(pix, 4'h9);
    for (int i = 0; i < 3; i++) begin
      pulse_update();
      repeat (40) @(negedge clk);
    end
    fd_exp += 2;
    wait_idle("pending_collapse", 5000);

    // Request held across the final transaction so one lands on the completion cycle.
    pix = rand_pix();
    bus_if.pixels = pix;
    push_frame(pix, 4'h9);
    pulse_update();
    count_cs_rises("back_to_back", 8, 3000);
    rises = 0; pk = bus_if.cs;
    for (int i = 0; i < 3000 && rises < 1; i++) begin
      @(negedge clk);
      if (bus_if.cs && !pk) rises++;
      pk = bus_if.cs;
    end
    pix = rand_pix();
    inten = 4'($urandom_range(0, 15));
    bus_if.pixels = pix; bus_if.intensity = inten;
    bus_if.update = 1'b1;
    push_frame(pix, inten);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.frame_done) begin
        bus_if.update = 1'b0;
        ok = 1;
        check("busy_at_back_to_back_done", bus_if.busy, 1);
        break;
      end
    end
    bus_if.update = 1'b0;
    check("back_to_back_done_seen", ok, 1);
    fd_exp += 2;
    wait_idle("back_to_back", 3000);

    // Reset 10 bits into a transaction aborts it and restarts init.
    pix = rand_pix();
    bus_if.pixels = pix;
    push_frame(pix, bus_if.intensity);
    pulse_update();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus_if.cs) begin ok = 1; break; end
    end
    check("abort_tx_started", ok, 1);
    rises = 0; pk = bus_if.sck;
    for (int i = 0; i < 500 && rises < 10; i++) begin
      @(negedge clk);
      if (bus_if.sck && !pk) rises++;
      pk = bus_if.sck;
    end
    check("abort_bits_seen", rises, 10);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); @(negedge clk);
    check("abort_cs_high", bus_if.cs, 1);
    check("abort_sck_low", bus_if.sck, 0);
    check("abort_busy_low", bus_if.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    push_init(bus_if.intensity);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("busy_after_abort_release", bus_if.busy, 1);
    wait_idle("reinit", 4000);

    for (int f = 0; f < 2; f++) begin
      pix = rand_pix();
      inten = 4'($urandom_range(0, 15));
      bus_if.pixels = pix; bus_if.intensity = inten;
      push_frame(pix, inten);
      fd_exp++;
      pulse_update();
      wait_idle("random_frame", 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max7219_chain_display.md
MAX7219_CHAIN_DISPLAY -- requirements
Module: max7219_chain_display

Interface
REQ-001 Parameter NUM_DEV, default 4, number of daisy-chained MAX7219 devices (1..8).
REQ-002 Parameter CLK_DIV, default 4, clk cycles per SCK half-period (>=1).
REQ-003 Parameter SCAN_LIMIT, default 3'd7, value written to scan-limit register.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pixels  input  64*NUM_DEV  frame; device d, digit k (0..7) = pixels[64*d+63-8*k -: 8].
REQ-007 intensity  input  4  brightness, sent as data 8'h0x to register 8'h0A.
REQ-008 update  input  1  single-cycle frame request.
REQ-009 busy  output  1  high while init or frame in progress.
REQ-010 frame_done  output  1  one-cycle pulse after last transaction of a frame.
REQ-011 sck  output  1  SPI clock, idle low.
REQ-012 mosi  output  1  SPI data, MSB first.
REQ-013 cs  output  1  chip select (LOAD), active-low.

Function
REQ-014 Transaction = cs low, 16*NUM_DEV bits, cs high; each device word = address byte then data byte; word for device NUM_DEV-1 shifted first.
REQ-015 Bit period = 2*CLK_DIV clk; mosi changes at bit-period start; sck low first CLK_DIV cycles, high last CLK_DIV cycles.
REQ-016 cs low exactly 32*NUM_DEV*CLK_DIV clk cycles per transaction; cs high at least 2*CLK_DIV cycles between transactions; sck low and mosi 0 whenever cs high.
REQ-017 Within one transaction all devices receive the same address; data per device as defined per step.
REQ-018 FSM states: INIT, IDLE, FRAME, plus shift sub-FSM LOAD, SHIFT, GAP.
REQ-019 INIT: 13 transactions in order: scan limit (0B, SCAN_LIMIT), decode (09, 00), shutdown (0C, 01), display test (0F, 00), intensity (0A, intensity), digits 01..08 data 00; then IDLE.
REQ-020 FRAME: 9 transactions: intensity, then digits 01..08 with per-device pixel data; then frame_done pulse, then IDLE.
REQ-021 pixels and intensity captured into internal registers in the cycle a frame starts; input changes during a frame have no effect on it.
REQ-022 update in IDLE starts FRAME next cycle; update during INIT or FRAME sets one pending flag; multiple requests collapse to one; pending frame starts immediately after current completes.
REQ-023 Simultaneous frame completion and update: pending set, new FRAME starts without IDLE visit; frame_done still pulses.
REQ-024 busy high from first cycle after rst release through INIT and FRAME, low only in IDLE with nothing pending.
REQ-025 Bit counter width ceil(log2(16*NUM_DEV+1)); no wrap-around within a transaction.

Reset
REQ-026 rst high: cs=1, sck=0, mosi=0, busy=0, frame_done=0, pending cleared, FSM to INIT.
REQ-027 rst asserted mid-transaction aborts it in the same cycle (cs=1 next cycle); INIT restarts from scan-limit after release.
REQ-028 busy=1 the first cycle after rst deasserts.

Configuration
REQ-029 Macro MAX7219_AUTO_REFRESH_EN defined: in IDLE a FRAME starts automatically each time frame_done fires plus 2*CLK_DIV cycles, update still accepted; undefined: FRAME only on update.

Verification
REQ-030 NUM_DEV=2, CLK_DIV=2, rst 4 cycles -> 13 transactions, each cs low 128 cycles, first word 0x0B07 0x0B07, then busy=0 (macro undefined).
REQ-031 pixels[127:120]=8'hA5, pixels[63:56]=8'h3C, update -> digit-1 transaction shifts 0x01A5 then 0x013C; frame_done one pulse after 9th transaction.
REQ-032 update 3x during FRAME -> exactly one further frame; then busy=0.
REQ-033 intensity=4'h9 changed mid-frame -> current frame keeps old value; next frame first word 0x0A09.
REQ-034 rst asserted at bit 10 of a transaction -> cs=1 and sck=0 next cycle; INIT restarts with 0x0B07.
REQ-035 MAX7219_AUTO_REFRESH_EN defined, no update -> frames repeat, frame_done period = 9*(128+gap) + 4 cycles.
